sram_controller: RTL and testbench
==================================

Name: sram_controller

Overview:
- Memory-side responder for the CPU's 5-bit memory control bus {we_n, ce_n, oe_n, lb_n, ub_n}, all active-low.
- Turns a single-cycle request into a correctly timed multi-cycle access on the board's asynchronous 16-bit SRAM: setup, strobe, hold and data turnaround.
- Returns read data plus busy/done status so the CPU side can stall.
- Sits between the I/O address decoder and the SRAM pins.

Parameters:
- ADDR_W, 18, SRAM address width; must be >= 16; upper bits are driven 0.
- DATA_W, 16, data width; fixed at 16 because byte lanes are lb/ub.
- WAIT_CYCLES, 2, cycles the strobe stays active; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  reset, synchronous, active-high.
- req  input  1  request strobe; sampled only in IDLE.
- ctl_in  input  5  {we_n, ce_n, oe_n, lb_n, ub_n} from the decoder.
- addr  input  16  word address.
- wdata  input  16  write data.
- rdata  output  16  captured read data.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- sram_addr  output  ADDR_W  SRAM address, equal to {0, latched addr}.
- sram_dq  inout  16  SRAM data bus.
- sram_ce_n, sram_we_n, sram_oe_n, sram_lb_n, sram_ub_n  output  1 each  SRAM strobes.

Behaviour:
- Reset values (synchronous, takes effect on the next edge, aborts any access in progress):
  - state IDLE.
  - all sram_*_n = 1.
  - sram_dq = Z; sram_addr = 0.
  - rdata = 0, busy = 0, done = 0.
- Accept condition: in IDLE with req=1 and ctl_in.ce_n=0.
  - Op select: we_n=0 gives WRITE, else oe_n=0 gives READ, else NOP.
  - If both we_n and oe_n are 0, WRITE wins.
  - NOP: no state change, no done.
  - On accept, latch addr, wdata, lb_n, ub_n and op. The latched values are held until IDLE regardless of input changes.
- States: IDLE, SETUP, ACCESS, HOLD, DONE. A wait counter is loaded with WAIT_CYCLES-1 on entry to ACCESS.
- WRITE sequence:
  - SETUP, 1 cycle: ce_n=0, we_n=1, oe_n=1, addr and lanes valid, dq driven with wdata.
  - ACCESS, WAIT_CYCLES cycles: we_n=0, dq driven.
  - HOLD, 1 cycle: we_n=1, ce_n=0, dq and addr still held.
  - DONE, 1 cycle: ce_n=1, dq=Z, done=1.
  - Total from accept to done: WAIT_CYCLES+3 cycles.
- READ sequence:
  - SETUP, 1 cycle: ce_n=0, oe_n=0, dq=Z.
  - ACCESS, WAIT_CYCLES cycles.
  - At the clock edge ending the last ACCESS cycle, capture sram_dq into rdata. A lane whose lb_n/ub_n = 1 is captured as 0.
  - Then go directly to DONE: oe_n=1, ce_n=1, done=1.
  - Total from accept to done: WAIT_CYCLES+2 cycles. rdata keeps its value until the next read completes.
- sram_dq is driven only in WRITE SETUP, ACCESS and HOLD; it is Z in every other cycle. The controller never drives the bus while oe_n=0.
- busy=1 from the cycle after accept through DONE inclusive. Any req while busy is ignored, with no queueing and no error.
- DONE always returns to IDLE. A new request can be accepted in the IDLE cycle that follows, so there is at least 1 idle cycle between accesses.
- Byte lanes: sram_lb_n/sram_ub_n = latched values during SETUP..HOLD and 1 elsewhere. lb_n=ub_n=1 is still a legal access: the strobes toggle with no lane enabled.
- Counter: it decrements in ACCESS. ACCESS exits when the count is 0, with no wrap-around. WAIT_CYCLES=1 gives exactly one ACCESS cycle.
- Reset asserted mid-access:
  - Outputs take their reset values at the next edge and done does not pulse.
  - A write interrupted in ACCESS ends with we_n=1 simultaneous with ce_n=1.
  - If reset and req are high together, reset wins.

Test Plan:
- Reset: hold reset 3 cycles during a WRITE in ACCESS -> next edge gives all strobes 1, dq=Z, busy=0, done=0, rdata=0.
- Write, WAIT_CYCLES=2: req with ctl_in=5'b00100, addr=0x1234, wdata=0xBEEF -> sram_addr=0x01234; dq=0xBEEF for SETUP, ACCESS and HOLD; we_n low exactly 2 cycles; done pulses at accept+5.
- Read: SRAM model returns 0xCAFE at 0x1234, req with ctl_in=5'b10000 -> oe_n low 3 cycles, rdata=0xCAFE, done at accept+4, dq never driven by the DUT.
- Byte read: ctl_in=5'b10001 (ub_n=1) with model data 0xCAFE -> sram_ub_n=1 throughout, rdata=0x00FE.
- Contention and priority: req pulsed every cycle while busy -> exactly one access completes. ctl_in=5'b00000 -> WRITE performed. ctl_in=5'b10100 -> NOP, busy stays 0.
- Back-to-back: write 0x5A5A to 0x0010 then read 0x0010 -> read accepted no earlier than 1 IDLE cycle after done, returns 0x5A5A. Repeat with WAIT_CYCLES=1 and 15 for latency checks.

Source files
------------

// File: rtl/sram_controller.sv
// Sequences a single-cycle CPU memory request into a timed setup/strobe/hold
// access on an asynchronous 16-bit SRAM, reporting busy/done and read data.
module sram_controller #(
    parameter int ADDR_W      = 18,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [4:0]        ctl_in,
    input  logic [15:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] sram_addr,
    inout  wire  [DATA_W-1:0] sram_dq,
    output logic              sram_ce_n,
    output logic              sram_we_n,
    output logic              sram_oe_n,
    output logic              sram_lb_n,
    output logic              sram_ub_n,
    output logic [2:0]        dbg_state,
    output logic              dbg_dq_oe
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_HOLD   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [15:0]         addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                lb_q, lb_d;
    logic                ub_q, ub_d;
    logic                wr_q, wr_d;
    logic                dq_oe;

    // Decoder bus order is {we_n, ce_n, oe_n, lb_n, ub_n}.
    logic ctl_we_n, ctl_ce_n, ctl_oe_n, ctl_lb_n, ctl_ub_n;
    assign {ctl_we_n, ctl_ce_n, ctl_oe_n, ctl_lb_n, ctl_ub_n} = ctl_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 16'd0;
            wdata_q <= '0;
            rdata_q <= '0;
            lb_q    <= 1'b1;
            ub_q    <= 1'b1;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            lb_q    <= lb_d;
            ub_q    <= ub_d;
            wr_q    <= wr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        lb_d    = lb_q;
        ub_d    = ub_q;
        wr_d    = wr_q;
        case (state_q)
            ST_IDLE: begin
                // A request that is neither write nor read is a NOP and never leaves IDLE.
                if (req && !ctl_ce_n && (!ctl_we_n || !ctl_oe_n)) begin
                    state_d = ST_SETUP;
                    addr_d  = addr;
                    wdata_d = wdata;
                    lb_d    = ctl_lb_n;
                    ub_d    = ctl_ub_n;
                    wr_d    = !ctl_we_n;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
                cnt_d   = CNT_LOAD;
            end
            ST_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    if (wr_q) begin
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_DONE;
                        rdata_d = {ub_q ? 8'h00 : sram_dq[15:8],
                                   lb_q ? 8'h00 : sram_dq[7:0]};
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_HOLD: state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Strobes decode straight from registered state so reset idles them at the next edge.
    always_comb begin
        sram_ce_n = 1'b1;
        sram_we_n = 1'b1;
        sram_oe_n = 1'b1;
        sram_lb_n = 1'b1;
        sram_ub_n = 1'b1;
        dq_oe     = 1'b0;
        case (state_q)
            ST_SETUP: begin
                sram_ce_n = 1'b0;
                sram_oe_n = wr_q;
                sram_lb_n = lb_q;
                sram_ub_n = ub_q;
                dq_oe     = wr_q;
            end
            ST_ACCESS: begin
                sram_ce_n = 1'b0;
                sram_we_n = !wr_q;
                sram_oe_n = wr_q;
                sram_lb_n = lb_q;
                sram_ub_n = ub_q;
                dq_oe     = wr_q;
            end
            ST_HOLD: begin
                sram_ce_n = 1'b0;
                sram_lb_n = lb_q;
                sram_ub_n = ub_q;
                dq_oe     = 1'b1;
            end
            default: ;
        endcase
    end

    assign sram_dq   = dq_oe ? wdata_q : {DATA_W{1'bz}};
    assign sram_addr = ADDR_W'(addr_q);
    assign rdata     = rdata_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign dbg_state = state_q;
    assign dbg_dq_oe = dq_oe;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: three instances (WAIT_CYCLES 2, 1, 15), each with
// a behavioural async SRAM, driven from a vector table plus reset sequences.
module tb_sram_controller;

    localparam int NI    = 3;
    localparam int OP_NOP = 0;
    localparam int OP_WR  = 1;
    localparam int OP_RD  = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    // ---------------- DUT-side signals ----------------
    logic [NI-1:0] req_v;
    logic [4:0]    ctl;
    logic [15:0]   addr;
    logic [15:0]   wdata;
    logic [15:0]   rdata_a [NI];
    logic          busy_a  [NI];
    logic          done_a  [NI];
    logic [17:0]   saddr_a [NI];
    logic          ce_a    [NI];
    logic          we_a    [NI];
    logic          oe_a    [NI];
    logic          lb_a    [NI];
    logic          ub_a    [NI];
    logic [2:0]    st_a    [NI];
    logic          dqoe_a  [NI];
    logic [15:0]   dq_obs  [NI];

    // backdoor preload into the SRAM models
    logic [NI-1:0] bd_we;
    logic [7:0]    bd_addr;
    logic [15:0]   bd_data;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int WC = (g == 0) ? 2 : (g == 1) ? 1 : 15;
        wire  [15:0] dq;
        logic [15:0] mem [256];
        logic        mdl_drv;

        // Asynchronous SRAM: drives data while selected with output enable and no write.
        assign mdl_drv   = !ce_a[g] && !oe_a[g] && we_a[g];
        assign dq        = mdl_drv ? mem[saddr_a[g][7:0]] : 16'hzzzz;
        assign dq_obs[g] = dq;

        always @(posedge clk) begin
            if (bd_we[g]) begin
                mem[bd_addr] <= bd_data;
            end else if (!ce_a[g] && !we_a[g]) begin
                if (!lb_a[g]) mem[saddr_a[g][7:0]][7:0]  <= dq[7:0];
                if (!ub_a[g]) mem[saddr_a[g][7:0]][15:8] <= dq[15:8];
            end
        end

        sram_controller #(
            .ADDR_W(18),
            .DATA_W(16),
            .WAIT_CYCLES(WC)
        ) u_dut (
            .clk(clk),
            .reset(reset),
            .req(req_v[g]),
            .ctl_in(ctl),
            .addr(addr),
            .wdata(wdata),
            .rdata(rdata_a[g]),
            .busy(busy_a[g]),
            .done(done_a[g]),
            .sram_addr(saddr_a[g]),
            .sram_dq(dq),
            .sram_ce_n(ce_a[g]),
            .sram_we_n(we_a[g]),
            .sram_oe_n(oe_a[g]),
            .sram_lb_n(lb_a[g]),
            .sram_ub_n(ub_a[g]),
            .dbg_state(st_a[g]),
            .dbg_dq_oe(dqoe_a[g])
        );
    end

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_err    = 0;
    logic [15:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s", name);
    endtask

    function automatic int wc_of(input int i);
        return (i == 0) ? 2 : (i == 1) ? 1 : 15;
    endfunction

    // {ce_n, we_n, oe_n, lb_n, ub_n, dq_driven, busy, done}
    function automatic logic [7:0] act_vec(input int i);
        return {ce_a[i], we_a[i], oe_a[i], lb_a[i], ub_a[i], dqoe_a[i], busy_a[i], done_a[i]};
    endfunction

    // Expected pins k cycles after the accepting edge.
    function automatic logic [7:0] exp_vec(input int op, input int w, input int k,
                                           input logic lb, input logic ub);
        int n;
        n = (op == OP_WR) ? w + 3 : (op == OP_RD) ? w + 2 : 0;
        if (op == OP_NOP || k > n) return 8'b11111_000;
        if (k == n)                return 8'b11111_011;
        if (op == OP_WR) begin
            if (k >= 2 && k <= w + 1) return {1'b0, 1'b0, 1'b1, lb, ub, 3'b110};
            return {1'b0, 1'b1, 1'b1, lb, ub, 3'b110};
        end
        return {1'b0, 1'b1, 1'b0, lb, ub, 3'b010};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic backdoor(input int i, input logic [7:0] a, input logic [15:0] d);
        bd_addr = a;
        bd_data = d;
        bd_we   = 3'b001 << i;
        @(negedge clk);
        bd_we   = '0;
    endtask

    typedef struct {
        int          inst;
        logic [4:0]  ctl;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        bit          preload;
        logic [15:0] pre_data;
        bit          hold_req;
    } vec_t;

    vec_t vq[$];

    task automatic add_vec(input int inst, input logic [4:0] c, input logic [15:0] a,
                           input logic [15:0] d, input logic [15:0] er,
                           input bit pl, input logic [15:0] pd, input bit hr);
        vec_t v;
        v.inst = inst; v.ctl = c; v.addr = a; v.wdata = d; v.exp_rdata = er;
        v.preload = pl; v.pre_data = pd; v.hold_req = hr;
        vq.push_back(v);
    endtask

    // Called just after a negedge; issues one request and checks every cycle to idle.
    task automatic run_access(input int idx, input vec_t v);
        int          op, n, last, w, i;
        logic [7:0]  ev;
        logic [15:0] exp_rd;
        i = v.inst;
        w = wc_of(i);
        if (v.preload) backdoor(i, v.addr[7:0], v.pre_data);
        op   = v.ctl[3] ? OP_NOP : !v.ctl[4] ? OP_WR : !v.ctl[2] ? OP_RD : OP_NOP;
        n    = (op == OP_WR) ? w + 3 : (op == OP_RD) ? w + 2 : 0;
        last = (op == OP_NOP) ? 3 : n + 1;
        ctl   = v.ctl;
        addr  = v.addr;
        wdata = v.wdata;
        req_v = 3'b001 << i;
        if (op != OP_NOP) exp_q.push_back(v.exp_rdata);
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            ev = exp_vec(op, w, k, v.ctl[1], v.ctl[0]);
            check($sformatf("v%0d_pins_k%0d", idx, k), 32'(act_vec(i)), 32'(ev));
            if (k == 1 && op != OP_NOP)
                check($sformatf("v%0d_sram_addr", idx), 32'(saddr_a[i]), 32'({2'b00, v.addr}));
            if (ev[2])
                check($sformatf("v%0d_dq_k%0d", idx, k), 32'(dq_obs[i]), 32'(v.wdata));
            if (done_a[i]) begin
                if (exp_q.size() == 0) begin
                    fail_now($sformatf("v%0d_unexpected_done", idx));
                end else begin
                    exp_rd = exp_q.pop_front();
                    check($sformatf("v%0d_rdata", idx), 32'(rdata_a[i]), 32'(exp_rd));
                end
            end
            if (!(v.hold_req && k < n)) req_v = '0;
            addr  = 16'($urandom_range(0, 65535));
            wdata = 16'($urandom_range(0, 65535));
        end
        if (exp_q.size() != 0) begin
            fail_now($sformatf("v%0d_done_missing", idx));
            exp_q.delete();
        end
    endtask

    task automatic check_reset_state(input string tag);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("%s_pins_i%0d", tag, i), 32'(act_vec(i)), 32'(8'b11111_000));
            check($sformatf("%s_rdata_i%0d", tag, i), 32'(rdata_a[i]), 32'h0);
            check($sformatf("%s_addr_i%0d", tag, i), 32'(saddr_a[i]), 32'h0);
            check($sformatf("%s_state_i%0d", tag, i), 32'(st_a[i]), 32'h0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        vec_t v;
        reset   = 1'b1;
        req_v   = '0;
        ctl     = 5'b11111;
        addr    = 16'h0;
        wdata   = 16'h0;
        bd_we   = '0;
        bd_addr = 8'h0;
        bd_data = 16'h0;
        repeat (2) @(negedge clk);
        check_reset_state("reset_init");
        reset = 1'b0;
        @(negedge clk);

        //      inst ctl        addr      wdata     exp_rdata pre pre_data  hold
        add_vec(0, 5'b00100, 16'h1234, 16'hBEEF, 16'h0000, 0, 16'h0000, 0);
        add_vec(0, 5'b10000, 16'h1234, 16'h0000, 16'hCAFE, 1, 16'hCAFE, 0);
        add_vec(0, 5'b10001, 16'h1234, 16'h0000, 16'h00FE, 0, 16'h0000, 0);
        add_vec(0, 5'b10010, 16'h1234, 16'h0000, 16'hCA00, 0, 16'h0000, 0);
        add_vec(0, 5'b00000, 16'h0020, 16'h1357, 16'hCA00, 0, 16'h0000, 0);
        add_vec(0, 5'b10000, 16'h0020, 16'h0000, 16'h1357, 0, 16'h0000, 0);
        add_vec(0, 5'b10100, 16'h0020, 16'h9999, 16'h0000, 0, 16'h0000, 0);
        add_vec(0, 5'b01000, 16'h0020, 16'h9999, 16'h0000, 0, 16'h0000, 0);
        add_vec(0, 5'b00100, 16'h0030, 16'h2468, 16'h1357, 0, 16'h0000, 1);
        add_vec(0, 5'b00101, 16'h0030, 16'hFFFF, 16'h1357, 0, 16'h0000, 0);
        add_vec(0, 5'b00111, 16'h0030, 16'h0000, 16'h1357, 0, 16'h0000, 0);
        add_vec(0, 5'b10000, 16'h0030, 16'h0000, 16'h24FF, 0, 16'h0000, 0);
        add_vec(0, 5'b10011, 16'h0030, 16'h0000, 16'h0000, 0, 16'h0000, 0);
        add_vec(0, 5'b00100, 16'h0010, 16'h5A5A, 16'h0000, 0, 16'h0000, 0);
        add_vec(0, 5'b10000, 16'h0010, 16'h0000, 16'h5A5A, 0, 16'h0000, 0);
        add_vec(1, 5'b00100, 16'h0010, 16'h5A5A, 16'h0000, 0, 16'h0000, 0);
        add_vec(1, 5'b10000, 16'h0010, 16'h0000, 16'h5A5A, 0, 16'h0000, 0);
        add_vec(2, 5'b00100, 16'h0010, 16'h5A5A, 16'h0000, 0, 16'h0000, 0);
        add_vec(2, 5'b10000, 16'h0010, 16'h0000, 16'h5A5A, 0, 16'h0000, 0);

        for (int j = 0; j < vq.size(); j++) run_access(j, vq[j]);

        // Reset during a write strobe, with req asserted alongside it.
        ctl   = 5'b00100;
        addr  = 16'h0040;
        wdata = 16'h1111;
        req_v = 3'b001;
        @(negedge clk);
        req_v = '0;
        @(negedge clk);
        check("rst_pre_access_pins", 32'(act_vec(0)), 32'(exp_vec(OP_WR, 2, 2, 1'b0, 1'b0)));
        reset = 1'b1;
        req_v = 3'b001;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c == 2) req_v = '0;
            check_reset_state($sformatf("rst_mid_c%0d", c));
        end
        reset = 1'b0;
        @(negedge clk);
        check("rst_release_pins", 32'(act_vec(0)), 32'(8'b11111_000));

        // Controller reset leaves SRAM contents alone.
        v.inst = 0; v.ctl = 5'b10000; v.addr = 16'h0010; v.wdata = 16'h0;
        v.exp_rdata = 16'h5A5A; v.preload = 0; v.pre_data = 16'h0; v.hold_req = 0;
        run_access(99, v);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
